mac_pipe: RTL and testbench

Parametrised, two-stage pipelined multiply-add/accumulate unit with valid/ready handshakes on input and output. It computes `A*B+C` or accumulates `A*B` into an internal accumulator, selected per operation. It is the general-width, flow-controlled successor of the team's fixed 8-bit single-register multiply-add block. It sits between a producer and consumer, each with a standard valid/ready interface.

---
 rtl/mac_pkg.sv | 23 ++
 rtl/mac_stage2.sv | 37 +++
 rtl/mac_pipe.sv | 113 +++++++++++
 tb/tb_mac_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the mac_pipe multiply-add/accumulate unit.
package mac_pkg;

   typedef enum logic [1:0] {
      MULADD = 2'd0,
      ACC    = 2'd1,
      LOAD   = 2'd2,
      RSVD   = 2'd3
   } mac_mode_t;

   localparam int unsigned MAC_SIZE_A        = 8;
   localparam int unsigned MAC_SIZE_B        = 8;
   localparam int unsigned MAC_SIZE_C        = 16;
   localparam int unsigned MAC_SIZE_DATA_OUT = 24;

   // Minimum result width that can hold any single A*B+C with its carry.
   function automatic int unsigned mac_sum_w(input int unsigned sa,
                                             input int unsigned sb,
                                             input int unsigned sc);
      return (((sa + sb) > sc) ? (sa + sb) : sc) + 1;
   endfunction

endpackage

// File: rtl/mac_stage2.sv
// Stage-2 datapath: adds the registered product to C or to the accumulator
// and decides whether the accumulator takes the truncated sum.
module mac_stage2
   import mac_pkg::*;
#(
   parameter int unsigned SIZE_P        = 16,
   parameter int unsigned SIZE_C        = 16,
   parameter int unsigned SIZE_DATA_OUT = 24
) (
   input  logic [SIZE_P-1:0]        prod_i,
   input  logic [SIZE_C-1:0]        c_i,
   input  mac_mode_t                mode_i,
   input  logic [SIZE_DATA_OUT-1:0] acc_i,
   output logic [SIZE_DATA_OUT:0]   sum_o,
   output logic                     acc_we_o,
   output logic [SIZE_DATA_OUT-1:0] acc_nxt_o
);

   logic [SIZE_DATA_OUT:0] addend;

   // RSVD falls through to the MULADD behaviour via the default arm.
   always_comb begin
      addend   = {{(SIZE_DATA_OUT + 1 - SIZE_C){1'b0}}, c_i};
      acc_we_o = 1'b0;
      unique case (mode_i)
         ACC: begin
            addend   = {1'b0, acc_i};
            acc_we_o = 1'b1;
         end
         LOAD:    acc_we_o = 1'b1;
         default: ;
      endcase
      sum_o     = {{(SIZE_DATA_OUT + 1 - SIZE_P){1'b0}}, prod_i} + addend;
      acc_nxt_o = sum_o[SIZE_DATA_OUT-1:0];
   end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-add/accumulate with valid/ready flow control;
// a single enable stalls both stages while the output is held.
module mac_pipe
   import mac_pkg::*;
#(
   parameter int unsigned SIZE_A        = MAC_SIZE_A,
   parameter int unsigned SIZE_B        = MAC_SIZE_B,
   parameter int unsigned SIZE_C        = MAC_SIZE_C,
   parameter int unsigned SIZE_DATA_OUT = MAC_SIZE_DATA_OUT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIZE_A-1:0]        A,
   input  logic [SIZE_B-1:0]        B,
   input  logic [SIZE_C-1:0]        C,
   input  logic [1:0]               mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIZE_DATA_OUT-1:0] DATA_OUT,
   output logic                     overflow
);

   localparam int unsigned SIZE_P = SIZE_A + SIZE_B;

   if (SIZE_DATA_OUT < mac_sum_w(SIZE_A, SIZE_B, SIZE_C)) begin : g_size_chk
      $error("mac_pipe: SIZE_DATA_OUT too small for A*B+C plus carry");
   end

   logic                     en;
   logic                     s1_valid_q, s1_valid_d;
   logic [SIZE_P-1:0]        prod_q, prod_d;
   logic [SIZE_C-1:0]        c_q, c_d;
   mac_mode_t                mode_q, mode_d;
   logic                     out_valid_q, out_valid_d;
   logic [SIZE_DATA_OUT-1:0] data_q, data_d;
   logic                     ovf_q, ovf_d;
   logic [SIZE_DATA_OUT-1:0] acc_q, acc_d;
   logic [SIZE_DATA_OUT:0]   sum;
   logic                     acc_we;
   logic [SIZE_DATA_OUT-1:0] acc_nxt;

   mac_stage2 #(
      .SIZE_P        (SIZE_P),
      .SIZE_C        (SIZE_C),
      .SIZE_DATA_OUT (SIZE_DATA_OUT)
   ) u_stage2 (
      .prod_i    (prod_q),
      .c_i       (c_q),
      .mode_i    (mode_q),
      .acc_i     (acc_q),
      .sum_o     (sum),
      .acc_we_o  (acc_we),
      .acc_nxt_o (acc_nxt)
   );

   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign DATA_OUT  = data_q;
   assign overflow  = ovf_q;

   // Accumulator is written only as an op leaves stage 1, so back-to-back
   // ACC ops always see the previous op's result.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      prod_d      = prod_q;
      c_d         = c_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      ovf_d       = ovf_q;
      acc_d       = acc_q;
      if (en) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            prod_d = {{SIZE_B{1'b0}}, A} * {{SIZE_A{1'b0}}, B};
            c_d    = C;
            mode_d = mac_mode_t'(mode);
         end
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d = sum[SIZE_DATA_OUT-1:0];
            ovf_d  = sum[SIZE_DATA_OUT];
            if (acc_we) acc_d = acc_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         prod_q      <= '0;
         c_q         <= '0;
         mode_q      <= MULADD;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         prod_q      <= prod_d;
         c_q         <= c_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         ovf_q       <= ovf_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_mac_pipe.sv
// Self-checking bench for mac_pipe: directed vectors plus a scoreboard of
// expected results, checked in order as each result retires.
module tb_mac_pipe;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  A         = '0;
   logic [7:0]  B         = '0;
   logic [15:0] C         = '0;
   logic [1:0]  mode      = '0;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] DATA_OUT;
   logic        overflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_ret = 0;
   int unsigned r0;
   longint      t0;
   logic [24:0] exp_q[$];
   logic [23:0] macc       = '0;
   logic [23:0] last_d     = '0;
   logic        last_o     = 1'b0;
   logic [23:0] prev_d     = '0;
   logic        prev_o     = 1'b0;
   logic        prev_stall = 1'b0;
   logic [24:0] mon_e;
   bit          rnd_or     = 1'b0;

   mac_pipe #(
      .SIZE_A        (8),
      .SIZE_B        (8),
      .SIZE_C        (16),
      .SIZE_DATA_OUT (24)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .DATA_OUT  (DATA_OUT),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Presents one op from posedge+1 until accepted; returns at posedge+1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] c, input logic [1:0] m);
      bit          ok = 1'b0;
      int unsigned t  = 0;
      logic [24:0] s;
      A = a; B = b; C = c; mode = m; in_valid = 1'b1;
      while (!ok && t < 1000) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_to", {31'b0, ok}, 1);
      else begin
         s = {17'b0, a} * {17'b0, b} + ((m == 2'd1) ? {1'b0, macc} : {9'b0, c});
         if (m == 2'd1 || m == 2'd2) macc = s[23:0];
         exp_q.push_back(s);
      end
   endtask

   task automatic drain();
      int unsigned t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (exp_q.size() != 0 && t < 200);
      if (exp_q.size() != 0) chk("drain_to", exp_q.size(), 0);
   endtask

   always @(posedge clk) begin
      #2;
      if (rnd_or) out_ready = 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_v", out_valid, 1);
            chk("hold_d", DATA_OUT, prev_d);
            chk("hold_o", overflow, prev_o);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious", out_valid, 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("res_d", DATA_OUT, mon_e[23:0]);
               chk("res_o", overflow, mon_e[24]);
            end
            last_d = DATA_OUT;
            last_o = overflow;
            n_ret++;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = DATA_OUT;
         prev_o     = overflow;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_v", out_valid, 0);
      chk("rst_d", DATA_OUT, 0);
      chk("rst_o", overflow, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdy", in_ready, 1);
      @(posedge clk);
      #1;

      issue(8'd3, 8'd4, 16'd5, 2'd0);
      @(negedge clk);
      chk("lat1", out_valid, 0);
      @(negedge clk);
      chk("lat2", out_valid, 1);
      drain();
      chk("muladd_d", last_d, 17);
      chk("muladd_o", last_o, 0);

      issue(8'd255, 8'd255, 16'd65535, 2'd0);
      drain();
      chk("max_d", last_d, 130560);
      chk("max_o", last_o, 0);

      t0 = $time;
      r0 = n_ret;
      for (int i = 0; i < 10; i++) issue(8'($urandom), 8'($urandom), 16'($urandom), 2'd0);
      chk("stream_cyc", 32'(($time - t0) / 10), 10);
      repeat (2) @(posedge clk);
      #1;
      chk("stream_n", n_ret - r0, 10);
      drain();

      issue(8'd0, 8'd0, 16'd0, 2'd2);
      for (int i = 0; i < 258; i++) issue(8'd255, 8'd255, 16'd0, 2'd1);
      drain();
      chk("acc258_d", last_d, 16776450);
      chk("acc258_o", last_o, 0);
      issue(8'd255, 8'd255, 16'd0, 2'd1);
      drain();
      chk("acc259_d", last_d, 64259);
      chk("acc259_o", last_o, 1);

      out_ready = 1'b0;
      r0 = n_ret;
      issue(8'd10, 8'd10, 16'd1, 2'd0);
      issue(8'd20, 8'd2, 16'd2, 2'd0);
      A = 8'd5; B = 8'd5; C = 16'd3; mode = 2'd0; in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("stall_rdy", in_ready, 0);
         chk("stall_d", DATA_OUT, 101);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      issue(8'd5, 8'd5, 16'd3, 2'd0);
      drain();
      chk("stall_n", n_ret - r0, 3);
      chk("stall_last", last_d, 28);

      r0 = n_ret;
      rnd_or = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         issue(8'($urandom), 8'($urandom), 16'($urandom), 2'($urandom));
      end
      rnd_or = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      chk("rand_n", n_ret - r0, 1000);

      issue(8'd0, 8'd0, 16'd1000, 2'd2);
      drain();
      chk("acc1000", last_d, 1000);
      issue(8'd1, 8'd2, 16'd0, 2'd1);
      issue(8'd1, 8'd1, 16'd0, 2'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_v", out_valid, 0);
      chk("rst_mid_d", DATA_OUT, 0);
      chk("rst_mid_o", overflow, 0);
      exp_q.delete();
      macc = '0;
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_rdy", in_ready, 1);
      @(posedge clk);
      #1;
      issue(8'd1, 8'd1, 16'd0, 2'd1);
      drain();
      chk("acc_clr_d", last_d, 1);
      chk("acc_clr_o", last_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
